draw_player_car: RTL

Overlay stage that draws the player car sprite onto the VGA bus and detects car/gremlin collisions. It sits directly downstream of `gremlins_position`, consuming the bus after gremlins are drawn and producing the bus that feeds the output pin registers. A small per-frame state machine moves the car, clamps it to the screen, latches collisions and freezes the car during a crash period.

---
 rtl/draw_player_car.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/draw_player_car.sv
// draw_player_car
//   Draws the player car sprite over the VGA bus, detects car/gremlin
//   collisions, and runs the per-frame drive/crash state machine.
//
//   Optional feature macro: CAR_BLINK_EN
//     defined   : the crashed car blinks in CAR_COLOR (visible while crash_cnt[2] = 0)
//     undefined : the crashed car is drawn solid in CRASH_COLOR
//
// Ports
//   pclk          in   pixel clock, rising edge
//   rst           in   synchronous active-high reset
//   vga_in        in   {vcount[10:0], vsync, vblnk, hcount[10:0], hsync, hblnk, rgb[11:0]}
//   vga_out       out  same fields delayed 2 cycles, rgb possibly replaced by the car
//   dir           in   heading 0=N .. 7=NW (N = y decreasing)
//   move          in   advance this frame (sampled at the frame edge)
//   rom_addr      out  sprite row for an external synchronous 16x16 ROM
//   rom_data      in   sprite row, valid 1 cycle after rom_addr, bit 15 = leftmost
//   xpos, ypos    out  car top-left position
//   crashed       out  high while in CRASH
//   collision_cnt out  saturating collision counter
//
// States
//   DRIVE | car moves with move/dir, collisions are detected
//   CRASH | car frozen for CRASH_FRAMES frames, collisions ignored

module draw_player_car #(
  parameter int          XPOS_INIT    = 400,
  parameter int          YPOS_INIT    = 500,
  parameter int          SPEED        = 2,
  parameter int          SCREEN_W     = 800,
  parameter int          SCREEN_H     = 600,
  parameter logic [11:0] CAR_COLOR    = 12'h0F0,
  parameter logic [11:0] CRASH_COLOR  = 12'hF00,
  parameter logic [11:0] GREM_COLOR   = 12'hFF0,
  parameter int          CRASH_FRAMES = 32,
  parameter int          VGA_BUS_SIZE = 38
) (
  input  logic                    pclk,
  input  logic                    rst,
  input  logic [VGA_BUS_SIZE-1:0] vga_in,
  output logic [VGA_BUS_SIZE-1:0] vga_out,
  input  logic [2:0]              dir,
  input  logic                    move,
  output logic [3:0]              rom_addr,
  input  logic [15:0]             rom_data,
  output logic [10:0]             xpos,
  output logic [10:0]             ypos,
  output logic                    crashed,
  output logic [7:0]              collision_cnt
);

  localparam int HBLNK  = 12;
  localparam int HC_LSB = 14;
  localparam int VBLNK  = 25;
  localparam int VC_LSB = 27;

  localparam logic signed [11:0] SPD   = 12'(SPEED);
  localparam logic signed [11:0] X_MAX = 12'(SCREEN_W - 16);
  localparam logic signed [11:0] Y_MAX = 12'(SCREEN_H - 16);

  typedef enum logic {DRIVE, CRASH} state_t;

  state_t state, state_next;
  logic [VGA_BUS_SIZE-1:0] bus1, bus2;
  logic        inside1, inside2;
  logic [3:0]  col1, col2;
  logic [11:0] hdiff, vdiff;
  logic        sprite_bit, hit, hit_latch, frame_edge;
  logic        car_visible;
  logic [11:0] car_rgb;
  logic [7:0]  crash_cnt, crash_cnt_next, collision_cnt_next;
  logic [10:0] xpos_next, ypos_next, x_clamped, y_clamped;
  logic signed [11:0] step_x, step_y, nx, ny;

  // 12-bit differences: a pixel left of / above the car wraps to a value >= 16.
  assign hdiff = {1'b0, vga_in[HC_LSB +: 11]} - {1'b0, xpos};
  assign vdiff = {1'b0, vga_in[VC_LSB +: 11]} - {1'b0, ypos};

  always_ff @(posedge pclk) begin
    if (rst) begin
      bus1     <= '0;
      bus2     <= '0;
      inside1  <= 1'b0;
      inside2  <= 1'b0;
      col1     <= '0;
      col2     <= '0;
      rom_addr <= '0;
    end else begin
      bus1     <= vga_in;
      inside1  <= (hdiff[11:4] == 8'd0) && (vdiff[11:4] == 8'd0);
      col1     <= hdiff[3:0];
      rom_addr <= vdiff[3:0];
      bus2     <= bus1;
      inside2  <= inside1;
      col2     <= col1;
    end
  end

  // rom_data arrives in the stage-2 cycle, so the bit is selected combinationally.
  assign sprite_bit = rom_data[4'd15 - col2];

  // Stage-1 vblnk against its stage-2 copy gives the 0->1 edge.
  assign frame_edge = bus1[VBLNK] && !bus2[VBLNK];

  assign hit = inside2 && sprite_bit && (bus2[11:0] == GREM_COLOR) &&
               !bus2[HBLNK] && !bus2[VBLNK] && (state == DRIVE);

  always_comb begin
`ifdef CAR_BLINK_EN
    car_visible = (state == DRIVE) || !crash_cnt[2];
    car_rgb     = CAR_COLOR;
`else
    car_visible = 1'b1;
    car_rgb     = (state == CRASH) ? CRASH_COLOR : CAR_COLOR;
`endif
  end

  always_comb begin
    vga_out = bus2;
    if (inside2 && sprite_bit && car_visible) vga_out[11:0] = car_rgb;
  end

  always_ff @(posedge pclk) begin
    if (rst)             hit_latch <= 1'b0;
    else if (frame_edge) hit_latch <= 1'b0;
    else if (hit)        hit_latch <= 1'b1;
  end

  always_comb begin
    step_x = '0;
    step_y = '0;
    case (dir)
      3'd0: step_y = -SPD;
      3'd1: begin step_x = SPD;  step_y = -SPD; end
      3'd2: step_x = SPD;
      3'd3: begin step_x = SPD;  step_y = SPD;  end
      3'd4: step_y = SPD;
      3'd5: begin step_x = -SPD; step_y = SPD;  end
      3'd6: step_x = -SPD;
      default: begin step_x = -SPD; step_y = -SPD; end
    endcase
    nx = $signed({1'b0, xpos}) + step_x;
    ny = $signed({1'b0, ypos}) + step_y;
    if (nx < 12'sd0)      x_clamped = '0;
    else if (nx > X_MAX)  x_clamped = X_MAX[10:0];
    else                  x_clamped = nx[10:0];
    if (ny < 12'sd0)      y_clamped = '0;
    else if (ny > Y_MAX)  y_clamped = Y_MAX[10:0];
    else                  y_clamped = ny[10:0];
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state         <= DRIVE;
      xpos          <= 11'(XPOS_INIT);
      ypos          <= 11'(YPOS_INIT);
      crash_cnt     <= '0;
      collision_cnt <= '0;
    end else begin
      state         <= state_next;
      xpos          <= xpos_next;
      ypos          <= ypos_next;
      crash_cnt     <= crash_cnt_next;
      collision_cnt <= collision_cnt_next;
    end
  end

  always_comb begin
    state_next         = state;
    xpos_next          = xpos;
    ypos_next          = ypos;
    crash_cnt_next     = crash_cnt;
    collision_cnt_next = collision_cnt;
    if (frame_edge) begin
      case (state)
        DRIVE: begin
          if (hit_latch) begin
            state_next     = CRASH;
            crash_cnt_next = 8'(CRASH_FRAMES - 1);
            if (collision_cnt != 8'hFF) collision_cnt_next = collision_cnt + 8'd1;
          end else if (move) begin
            xpos_next = x_clamped;
            ypos_next = y_clamped;
          end
        end
        default: begin
          if (crash_cnt == 8'd0) state_next = DRIVE;
          else                   crash_cnt_next = crash_cnt - 8'd1;
        end
      endcase
    end
  end

  assign crashed = (state == CRASH);

endmodule
